// File: rtl/rref_op_scheduler.sv
// rref_op_scheduler: pivot search and SWAP/NORM/ELIM sequencing for Gauss-Jordan on [A|B].
// Optional feature macro: ELIM_SKIP_ZERO_EN (zero-check each target row before its ELIM).
module rref_op_scheduler #(
   parameter int N = 5,
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         abort,
   output logic         busy,
   output logic         done,
   output logic         singular,
   output logic         cmd_valid,
   input  logic         cmd_ready,
   output logic [1:0]   cmd_op,
   output logic [2:0]   cmd_row_k,
   output logic [2:0]   cmd_row_i,
   input  logic         op_done,
   output logic [2:0]   rd_row,
   output logic [2:0]   rd_col,
   input  logic [W-1:0] rd_data
);

   localparam logic [1:0] OP_SWAP = 2'b00;
   localparam logic [1:0] OP_NORM = 2'b01;
   localparam logic [1:0] OP_ELIM = 2'b10;
   localparam logic [3:0] LAST    = 4'(N - 1);

   typedef enum logic [2:0] {
      IDLE, SRCH, ISSUE, WAIT, NEXT, FIN, SKCHK
   } state_t;

   state_t     state, state_n;
   logic [2:0] k, k_n;
   logic [2:0] r, r_n;
   logic [2:0] i, i_n;
   logic [1:0] op, op_n;
   logic       sing_n;
   logic       nz;
   logic [3:0] i_first;
   logic [3:0] i_step;
   logic [3:0] nxt_i;

   assign nz = |rd_data;

   // Row walk for eliminations: ascending, never landing on the pivot row.
   always_comb begin
      i_first = (k == 3'd0) ? 4'd1 : 4'd0;
      i_step  = {1'b0, i} + 4'd1;
      if (i_step == {1'b0, k})
         i_step = i_step + 4'd1;
      nxt_i = (op == OP_NORM) ? i_first : i_step;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         k        <= '0;
         r        <= '0;
         i        <= '0;
         op       <= OP_SWAP;
         singular <= 1'b0;
      end else begin
         state    <= state_n;
         k        <= k_n;
         r        <= r_n;
         i        <= i_n;
         op       <= op_n;
         singular <= sing_n;
      end
   end

   always_comb begin
      state_n = state;
      k_n     = k;
      r_n     = r;
      i_n     = i;
      op_n    = op;
      sing_n  = singular;
      if (abort) begin
         state_n = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state_n = SRCH;
                  k_n     = '0;
                  r_n     = '0;
                  sing_n  = 1'b0;
               end
            end
            SRCH: begin
               if (nz) begin
                  state_n = ISSUE;
                  if (r == k) begin
                     op_n = OP_NORM;
                     i_n  = '0;
                  end else begin
                     op_n = OP_SWAP;
                     i_n  = r;
                  end
               end else if ({1'b0, r} == LAST) begin
                  state_n = FIN;
                  sing_n  = 1'b1;
               end else begin
                  r_n = r + 3'd1;
               end
            end
            ISSUE: begin
               if (cmd_ready)
                  state_n = WAIT;
            end
            WAIT: begin
               if (op_done) begin
                  if (op == OP_SWAP) begin
                     op_n    = OP_NORM;
                     i_n     = '0;
                     state_n = ISSUE;
                  end else if (nxt_i > LAST) begin
                     state_n = NEXT;
                  end else begin
                     op_n    = OP_ELIM;
                     i_n     = nxt_i[2:0];
`ifdef ELIM_SKIP_ZERO_EN
                     state_n = SKCHK;
`else
                     state_n = ISSUE;
`endif
                  end
               end
            end
            NEXT: begin
               if ({1'b0, k} == LAST) begin
                  state_n = FIN;
               end else begin
                  k_n     = k + 3'd1;
                  r_n     = k + 3'd1;
                  state_n = SRCH;
               end
            end
            FIN: state_n = IDLE;
`ifdef ELIM_SKIP_ZERO_EN
            // A zero multiplier leaves the row unchanged, so no command is needed.
            SKCHK: begin
               if (nz)
                  state_n = ISSUE;
               else if (i_step > LAST)
                  state_n = NEXT;
               else
                  i_n = i_step[2:0];
            end
`endif
            default: state_n = IDLE;
         endcase
      end
   end

   always_comb begin
      busy      = state inside {SRCH, ISSUE, WAIT, NEXT, SKCHK};
      done      = (state == FIN);
      cmd_valid = (state == ISSUE);
      cmd_op    = op;
      cmd_row_k = k;
      cmd_row_i = i;
      rd_row    = '0;
      rd_col    = '0;
      if (state == SRCH) begin
         rd_row = r;
         rd_col = k;
      end else if (state == SKCHK) begin
         rd_row = i;
         rd_col = k;
      end
   end

endmodule
